// File: rtl/shift_add_mult_seq.sv
// Iterative shift-and-add multiplier: one WIDTH-bit adder row reused over WIDTH cycles.
// Latency: accept at edge t, io_out_valid rises after edge t+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: io_in_ready low while busy; the product is held in DONE until io_out_ready.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   io_in_valid/ready   operand handshake (io_in_a multiplicand, io_in_b multiplier)
//   io_out_valid/ready  result handshake (io_out_result = io_in_a * io_in_b, 2*WIDTH bits)
//   io_busy             high while an operation is running or waiting to be taken
module shift_add_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WIDTH-1:0]     io_in_a,
  input  logic [WIDTH-1:0]     io_in_b,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [2*WIDTH-1:0]   io_out_result,
  output logic                 io_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_q;
  // p_q holds the partial product in its upper half and the not-yet-consumed
  // multiplier bits in its lower half; both shift right together each step.
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic               accept;

  // One adder row: upper half of P plus the multiplicand gated by the current
  // multiplier bit. The carry is kept and becomes the new MSB of P.
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  end

  assign io_in_ready   = (state == ST_IDLE) & ~reset;
  assign io_out_valid  = (state == ST_DONE);
  assign io_busy       = (state != ST_IDLE);
  assign io_out_result = p_q;

  assign accept = io_in_valid & io_in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      p_q   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Operands are sampled only here; P keeps the last product otherwise.
          if (accept) begin
            a_q   <= io_in_a;
            p_q   <= {{WIDTH{1'b0}}, io_in_b};
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Fixed latency: always WIDTH steps, even for zero operands.
          p_q <= {sum, p_q[WIDTH-1:1]};
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io_out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
